gpu_rect_engine: RTL and testbench
==================================

Name: gpu_rect_engine

Overview:
- Parametrised rectangle engine for the GPU-SRAM port: accepts one rectangle command and walks the covered pixels of a linear framebuffer in SRAM.
- Supports two modes: FILL (write a constant colour) and INVERT (read-modify-write, bitwise NOT).
- Sits between the GPU command logic and the shared SRAM bus. SRAM is only touched while the display is not scanning (I_VIDEO_ON low).
- Generalises the fixed-size GPU SRAM master: framebuffer geometry, data width and address width are parameters, and it adds clipping, video-gated stalls and progress reporting.

Parameters:
- DW, 16, pixel / SRAM data width
- AW, 19, SRAM address width
- XW, 10, width of x / w coordinate fields
- YW, 9, width of y / h coordinate fields
- SCREEN_W, 640, framebuffer pixels per row
- SCREEN_H, 480, framebuffer rows
- BASE_ADDR, 0, SRAM address of pixel (0,0)

Ports:
- I_CLK  in  1  clock, all logic on rising edge
- I_RST  in  1  asynchronous active-high reset
- I_VIDEO_ON  in  1  1 = display scanning, SRAM access forbidden
- I_CMD_VALID  in  1  command present
- O_CMD_READY  out  1  engine idle, command can be accepted
- I_CMD_MODE  in  1  0 = FILL, 1 = INVERT
- I_CMD_X  in  XW  left column
- I_CMD_Y  in  YW  top row
- I_CMD_W  in  XW  width in pixels
- I_CMD_H  in  YW  height in rows
- I_CMD_COLOR  in  DW  fill colour (FILL mode only)
- I_GPU_DATA  in  DW  SRAM read data, valid the cycle after O_GPU_READ
- O_GPU_DATA  out  DW  SRAM write data
- O_GPU_ADDR  out  AW  SRAM address
- O_GPU_READ  out  1  one-cycle read strobe
- O_GPU_WRITE  out  1  one-cycle write strobe
- O_BUSY  out  1  command in progress
- O_DONE  out  1  one-cycle completion pulse
- O_PIX_CNT  out  16  pixels written by the last or current command (saturates at 16'hFFFF)

Behaviour:
- Reset (async, any state): state IDLE; O_CMD_READY=1; O_GPU_READ=0; O_GPU_WRITE=0; O_GPU_DATA=0; O_GPU_ADDR=0; O_BUSY=0; O_DONE=0; O_PIX_CNT=0. Reset in the middle of a command abandons it with no further strobes.
- Accept: command is accepted on a rising edge with I_CMD_VALID & O_CMD_READY. O_CMD_READY=1 only in IDLE.
- On accept:
  - Latch mode and colour; clear O_PIX_CNT.
  - Clip: w_eff = min(W, SCREEN_W-X) and h_eff = min(H, SCREEN_H-Y). If X>=SCREEN_W or Y>=SCREEN_H, the command is empty.
  - Row start = BASE_ADDR + Y*SCREEN_W + X. The multiply is evaluated once, at accept only.
- States:
  - IDLE: wait for accept.
  - Accept goes to DONE if w_eff==0 or h_eff==0; otherwise to WAIT_VIDEO.
  - WAIT_VIDEO: go to FILL_WR (FILL) or RD (INVERT) on the first cycle with I_VIDEO_ON=0.
  - FILL_WR: O_GPU_WRITE=1, O_GPU_DATA=colour, O_GPU_ADDR=current pixel. Advance one pixel per cycle while I_VIDEO_ON=0. If I_VIDEO_ON=1, deassert strobes and go to WAIT_VIDEO without advancing.
  - RD: O_GPU_READ=1 for one cycle, then go to CAP.
  - CAP: capture ~I_GPU_DATA. Go to WR if I_VIDEO_ON=0; otherwise hold the captured value and go to WAIT_VIDEO_WR.
  - WAIT_VIDEO_WR: go to WR on the first cycle with I_VIDEO_ON=0.
  - WR: O_GPU_WRITE=1, data = captured value. Advance one pixel, then go to RD (or WAIT_VIDEO if I_VIDEO_ON=1).
  - After the last pixel's write, go to DONE.
  - DONE: O_DONE=1 for exactly one cycle, then IDLE.
- Timing:
  - FILL: first strobe in the cycle after accept if video is off; one pixel per cycle; O_DONE the cycle after the last write.
  - INVERT: 3 cycles per pixel (RD, CAP, WR).
- Address walk:
  - Along a row: address +1.
  - At row end: row_start += SCREEN_W, and the address reloads to the new row_start.
  - Address arithmetic is AW bits and wraps mod 2^AW. No wrap occurs with default parameters.
- Strobes: O_GPU_READ and O_GPU_WRITE are never high together. Neither is ever high in a cycle where I_VIDEO_ON=1.
- O_PIX_CNT increments on every write strobe.
- O_BUSY = not IDLE. It is high in DONE.
- I_CMD_* fields are ignored while busy.

Test Plan:
- Reset asserted then released, I_VIDEO_ON=0 -> all outputs 0, O_CMD_READY=1, no strobes.
- FILL X=2 Y=1 W=3 H=2 COLOR=16'hF800 -> write strobes on 6 consecutive cycles at addresses 642, 643, 644, 1282, 1283, 1284, all data F800; O_DONE one cycle later; O_PIX_CNT=6.
- INVERT X=100 Y=0 W=1 H=1, SRAM model returns 16'h00FF -> one read at 100, write 16'hFF00 at 100 two cycles later, then O_DONE.
- FILL W=4 H=1 at X=0 Y=0, I_VIDEO_ON pulsed high for 5 cycles after the 2nd write -> no strobe while high; writes resume at address 2; total 4 writes; O_PIX_CNT=4.
- Clipping: FILL X=638 W=5 H=1 Y=479 -> writes only at 307198 and 307199. Separately, X=640 or H=0 -> O_DONE the cycle after accept, zero strobes.
- I_RST pulsed after the 3rd write of a W=10 FILL -> all strobes drop immediately, O_BUSY=0, O_PIX_CNT=0, a new command is accepted.

Source files
------------

// File: rtl/gpu_rect_engine_if.sv
// gpu_rect_engine_if
//   Groups the signals that connect the rectangle engine to the GPU
//   command logic and to the shared SRAM bus.
//   Command side : I_CMD_VALID / O_CMD_READY handshake with the mode, x, y,
//                  w, h and colour fields, plus O_BUSY, O_DONE and O_PIX_CNT.
//   SRAM side    : O_GPU_ADDR, O_GPU_DATA, O_GPU_READ, O_GPU_WRITE, I_GPU_DATA.
//   Video gate   : I_VIDEO_ON (1 = display scanning, SRAM off limits).
//   Modports     : slave = the engine, master = whoever drives commands and
//                  models the SRAM.
interface gpu_rect_engine_if #(
   parameter int DW = 16,
   parameter int AW = 19,
   parameter int XW = 10,
   parameter int YW = 9
);
   logic          I_VIDEO_ON;
   logic          I_CMD_VALID;
   logic          O_CMD_READY;
   logic          I_CMD_MODE;
   logic [XW-1:0] I_CMD_X;
   logic [YW-1:0] I_CMD_Y;
   logic [XW-1:0] I_CMD_W;
   logic [YW-1:0] I_CMD_H;
   logic [DW-1:0] I_CMD_COLOR;
   logic [DW-1:0] I_GPU_DATA;
   logic [DW-1:0] O_GPU_DATA;
   logic [AW-1:0] O_GPU_ADDR;
   logic          O_GPU_READ;
   logic          O_GPU_WRITE;
   logic          O_BUSY;
   logic          O_DONE;
   logic [15:0]   O_PIX_CNT;

   modport slave (
      input  I_VIDEO_ON, I_CMD_VALID, I_CMD_MODE, I_CMD_X, I_CMD_Y,
             I_CMD_W, I_CMD_H, I_CMD_COLOR, I_GPU_DATA,
      output O_CMD_READY, O_GPU_DATA, O_GPU_ADDR, O_GPU_READ, O_GPU_WRITE,
             O_BUSY, O_DONE, O_PIX_CNT
   );

   modport master (
      output I_VIDEO_ON, I_CMD_VALID, I_CMD_MODE, I_CMD_X, I_CMD_Y,
             I_CMD_W, I_CMD_H, I_CMD_COLOR, I_GPU_DATA,
      input  O_CMD_READY, O_GPU_DATA, O_GPU_ADDR, O_GPU_READ, O_GPU_WRITE,
             O_BUSY, O_DONE, O_PIX_CNT
   );
endinterface

// File: rtl/gpu_rect_engine.sv
// gpu_rect_engine
//   Walks the pixels of one clipped rectangle in a linear framebuffer held
//   in SRAM. FILL writes a constant colour, one pixel per cycle. INVERT does
//   read / capture / write per pixel, storing the bitwise NOT of the data read.
//   SRAM strobes are gated off in any cycle where I_VIDEO_ON is high.
// Ports
//   I_CLK : clock, rising edge
//   I_RST : asynchronous active-high reset
//   bus   : gpu_rect_engine_if.slave (command handshake, SRAM bus, status)
module gpu_rect_engine #(
   parameter int DW        = 16,
   parameter int AW        = 19,
   parameter int XW        = 10,
   parameter int YW        = 9,
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int BASE_ADDR = 0
) (
   input logic             I_CLK,
   input logic             I_RST,
   gpu_rect_engine_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_VIDEO, S_FILL_WR, S_RD, S_CAP, S_WAIT_VIDEO_WR, S_WR, S_DONE
   } state_t;

   localparam logic [XW:0]   SW_L   = (XW+1)'(SCREEN_W);
   localparam logic [YW:0]   SH_L   = (YW+1)'(SCREEN_H);
   localparam logic [AW-1:0] SW_A   = AW'(SCREEN_W);
   localparam logic [AW-1:0] BASE_A = AW'(BASE_ADDR);

   state_t        state_q, state_d;
   logic          mode_q, mode_d;
   logic [DW-1:0] color_q, color_d;
   logic [DW-1:0] inv_q, inv_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] row_start_q, row_start_d;
   logic [XW-1:0] w_q, w_d, col_q, col_d;
   logic [YW-1:0] h_q, h_d, row_q, row_d;
   logic [15:0]   pix_q, pix_d;

   logic          rd_stb, wr_stb, adv;
   logic [XW:0]   w_room;
   logic [YW:0]   h_room;
   logic [XW-1:0] w_clip;
   logic [YW-1:0] h_clip;
   logic [AW-1:0] start_addr;

   // Clipping and row-start address of the command on the bus. Only used at
   // accept, so the multiplier is evaluated once per command.
   always_comb begin
      w_room = SW_L - {1'b0, bus.I_CMD_X};
      h_room = SH_L - {1'b0, bus.I_CMD_Y};
      if ({1'b0, bus.I_CMD_X} >= SW_L)
         w_clip = '0;
      else if ({1'b0, bus.I_CMD_W} < w_room)
         w_clip = bus.I_CMD_W;
      else
         w_clip = w_room[XW-1:0];
      if ({1'b0, bus.I_CMD_Y} >= SH_L)
         h_clip = '0;
      else if ({1'b0, bus.I_CMD_H} < h_room)
         h_clip = bus.I_CMD_H;
      else
         h_clip = h_room[YW-1:0];
      start_addr = BASE_A + AW'(bus.I_CMD_Y) * SW_A + AW'(bus.I_CMD_X);
   end

   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         state_q     <= S_IDLE;
         mode_q      <= 1'b0;
         color_q     <= '0;
         inv_q       <= '0;
         addr_q      <= '0;
         row_start_q <= '0;
         w_q         <= '0;
         h_q         <= '0;
         col_q       <= '0;
         row_q       <= '0;
         pix_q       <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         color_q     <= color_d;
         inv_q       <= inv_d;
         addr_q      <= addr_d;
         row_start_q <= row_start_d;
         w_q         <= w_d;
         h_q         <= h_d;
         col_q       <= col_d;
         row_q       <= row_d;
         pix_q       <= pix_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      color_d     = color_q;
      inv_d       = inv_q;
      addr_d      = addr_q;
      row_start_d = row_start_q;
      w_d         = w_q;
      h_d         = h_q;
      col_d       = col_q;
      row_d       = row_q;
      pix_d       = pix_q;
      rd_stb      = 1'b0;
      wr_stb      = 1'b0;
      adv         = 1'b0;

      // Access states test I_VIDEO_ON themselves, so accept jumps straight
      // to the first access state and a quiet display gets its strobe in the
      // very next cycle.
      unique case (state_q)
         S_IDLE: begin
            if (bus.I_CMD_VALID) begin
               mode_d      = bus.I_CMD_MODE;
               color_d     = bus.I_CMD_COLOR;
               pix_d       = '0;
               w_d         = w_clip;
               h_d         = h_clip;
               col_d       = '0;
               row_d       = '0;
               row_start_d = start_addr;
               addr_d      = start_addr;
               if (w_clip == '0 || h_clip == '0)
                  state_d = S_DONE;
               else
                  state_d = bus.I_CMD_MODE ? S_RD : S_FILL_WR;
            end
         end
         S_WAIT_VIDEO: begin
            if (!bus.I_VIDEO_ON) state_d = mode_q ? S_RD : S_FILL_WR;
         end
         S_FILL_WR: begin
            if (bus.I_VIDEO_ON) begin
               state_d = S_WAIT_VIDEO;
            end else begin
               wr_stb = 1'b1;
               adv    = 1'b1;
            end
         end
         S_RD: begin
            if (bus.I_VIDEO_ON) begin
               state_d = S_WAIT_VIDEO;
            end else begin
               rd_stb  = 1'b1;
               state_d = S_CAP;
            end
         end
         S_CAP: begin
            inv_d   = ~bus.I_GPU_DATA;
            state_d = bus.I_VIDEO_ON ? S_WAIT_VIDEO_WR : S_WR;
         end
         S_WAIT_VIDEO_WR: begin
            if (!bus.I_VIDEO_ON) state_d = S_WR;
         end
         S_WR: begin
            if (bus.I_VIDEO_ON) begin
               state_d = S_WAIT_VIDEO_WR;
            end else begin
               wr_stb  = 1'b1;
               adv     = 1'b1;
               state_d = S_RD;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Pixel advance after a write: step along the row, or reload the
      // address from the next row start, or finish after the last pixel.
      if (adv) begin
         pix_d = (pix_q == 16'hFFFF) ? pix_q : pix_q + 16'd1;
         if (col_q == w_q - XW'(1)) begin
            if (row_q == h_q - YW'(1)) begin
               state_d = S_DONE;
            end else begin
               row_d       = row_q + YW'(1);
               col_d       = '0;
               row_start_d = row_start_q + SW_A;
               addr_d      = row_start_q + SW_A;
            end
         end else begin
            col_d  = col_q + XW'(1);
            addr_d = addr_q + AW'(1);
         end
      end
   end

   assign bus.O_CMD_READY = (state_q == S_IDLE);
   assign bus.O_BUSY      = (state_q != S_IDLE);
   assign bus.O_DONE      = (state_q == S_DONE);
   assign bus.O_GPU_READ  = rd_stb;
   assign bus.O_GPU_WRITE = wr_stb;
   assign bus.O_GPU_ADDR  = addr_q;
   assign bus.O_GPU_DATA  = mode_q ? inv_q : color_q;
   assign bus.O_PIX_CNT   = pix_q;
endmodule

// File: tb/tb_gpu_rect_engine.sv
// tb_gpu_rect_engine
//   Directed and randomized rectangle commands against a pixel-list model
//   of the framebuffer walk and a simple SRAM model.
module tb_gpu_rect_engine;
   localparam int DW = 16, AW = 19, XW = 10, YW = 9;
   localparam int SW = 640, SH = 480, BASE = 0;
   localparam int FB = SW * SH;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gpu_rect_engine_if #(.DW(DW), .AW(AW), .XW(XW), .YW(YW)) bus ();

   gpu_rect_engine #(
      .DW(DW), .AW(AW), .XW(XW), .YW(YW),
      .SCREEN_W(SW), .SCREEN_H(SH), .BASE_ADDR(BASE)
   ) dut (
      .I_CLK (clk),
      .I_RST (rst),
      .bus   (bus.slave)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int acc_cyc = 0;

   // SRAM model
   bit [15:0] mem [FB];
   bit        written [FB];
   bit        ovr_en = 1'b0;
   logic [15:0] ovr_val = 16'h0000;

   function automatic logic [15:0] sram_val(input int a);
      if (ovr_en) return ovr_val;
      if (a >= 0 && a < FB && written[a]) return mem[a];
      return 16'(a * 37 + 5);
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.O_GPU_READ) bus.I_GPU_DATA <= sram_val(int'(bus.O_GPU_ADDR));
      if (bus.O_GPU_WRITE && !rst && int'(bus.O_GPU_ADDR) < FB) begin
         mem[bus.O_GPU_ADDR]     <= bus.O_GPU_DATA;
         written[bus.O_GPU_ADDR] <= 1'b1;
      end
   end

   // Video gate: forced high, randomly toggled, or low.
   bit vid_force = 1'b0;
   bit vid_rand  = 1'b0;
   always @(posedge clk) begin
      #2;
      bus.I_VIDEO_ON = vid_force || (vid_rand && ($urandom_range(0, 3) == 0));
   end

   // Bus monitor
   int          wa_q[$], wc_q[$], ra_q[$], rc_q[$];
   logic [15:0] wd_q[$];
   int          viol = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.O_GPU_WRITE) begin
            wa_q.push_back(int'(bus.O_GPU_ADDR));
            wd_q.push_back(bus.O_GPU_DATA);
            wc_q.push_back(cyc);
         end
         if (bus.O_GPU_READ) begin
            ra_q.push_back(int'(bus.O_GPU_ADDR));
            rc_q.push_back(cyc);
         end
         if ((bus.O_GPU_READ && bus.O_GPU_WRITE) ||
             ((bus.O_GPU_READ || bus.O_GPU_WRITE) && bus.I_VIDEO_ON))
            viol = viol + 1;
         if (bus.O_DONE) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
         end
      end
   end

   // Reference model: expected pixel list of a command
   int          ea_q[$];
   logic [15:0] ed_q[$];

   task automatic build(input bit m, input int x, input int y, input int w, input int h,
                        input logic [15:0] c);
      int we, he, a;
      ea_q.delete();
      ed_q.delete();
      we = (x >= SW) ? 0 : ((w < SW - x) ? w : SW - x);
      he = (y >= SH) ? 0 : ((h < SH - y) ? h : SH - y);
      for (int r = 0; r < he; r++)
         for (int cc = 0; cc < we; cc++) begin
            a = BASE + (y + r) * SW + x + cc;
            ea_q.push_back(a);
            ed_q.push_back(m ? ~sram_val(a) : c);
         end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic issue(input bit m, input int x, input int y, input int w, input int h,
                        input logic [15:0] c);
      build(m, x, y, w, h, c);
      wa_q.delete(); wd_q.delete(); wc_q.delete(); ra_q.delete(); rc_q.delete();
      viol = 0;
      done_cnt = 0;
      @(negedge clk);
      bus.I_CMD_VALID = 1'b1;
      bus.I_CMD_MODE  = m;
      bus.I_CMD_X     = XW'(x);
      bus.I_CMD_Y     = YW'(y);
      bus.I_CMD_W     = XW'(w);
      bus.I_CMD_H     = YW'(h);
      bus.I_CMD_COLOR = c;
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      bus.I_CMD_VALID = 1'b0;
      // Scramble fields while busy: the engine must use its latched copy.
      bus.I_CMD_MODE  = 1'($urandom);
      bus.I_CMD_X     = XW'($urandom);
      bus.I_CMD_Y     = YW'($urandom);
      bus.I_CMD_W     = XW'($urandom);
      bus.I_CMD_H     = YW'($urandom);
      bus.I_CMD_COLOR = 16'($urandom);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done_cnt == 0 && n < 5000) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk({tag, "_done_seen"}, done_cnt != 0, 1);
      chk({tag, "_idle_after"}, {bus.O_CMD_READY, bus.O_BUSY, bus.O_DONE}, 3'b100);
   endtask

   task automatic check_cmd(input string tag, input bit m, input bit timing);
      int n;
      n = ea_q.size();
      chk({tag, "_nwr"}, wa_q.size(), n);
      chk({tag, "_nrd"}, ra_q.size(), m ? n : 0);
      for (int i = 0; i < n; i++) begin
         if (i < wa_q.size()) begin
            chk($sformatf("%s_wa%0d", tag, i), wa_q[i], ea_q[i]);
            chk($sformatf("%s_wd%0d", tag, i), wd_q[i], ed_q[i]);
            if (timing) chk($sformatf("%s_wc%0d", tag, i), wc_q[i], acc_cyc + (m ? 3 * i + 2 : i));
         end
         if (m && i < ra_q.size()) begin
            chk($sformatf("%s_ra%0d", tag, i), ra_q[i], ea_q[i]);
            if (timing) chk($sformatf("%s_rc%0d", tag, i), rc_q[i], acc_cyc + 3 * i);
         end
      end
      chk({tag, "_pix"}, bus.O_PIX_CNT, n);
      chk({tag, "_strobe_rules"}, viol, 0);
      chk({tag, "_done_once"}, done_cnt, 1);
      if (timing) chk({tag, "_done_cyc"}, done_cyc, acc_cyc + (m ? 3 * n : n));
   endtask

   initial begin
      int x, y, w, h, n;
      bit m;
      bus.I_CMD_VALID = 1'b0;
      bus.I_CMD_MODE  = 1'b0;
      bus.I_CMD_X     = '0;
      bus.I_CMD_Y     = '0;
      bus.I_CMD_W     = '0;
      bus.I_CMD_H     = '0;
      bus.I_CMD_COLOR = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_held_ready", bus.O_CMD_READY, 1'b1);
      chk("rst_held_strobes", {bus.O_GPU_READ, bus.O_GPU_WRITE}, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", bus.O_CMD_READY, 1'b1);
      chk("rst_busy", bus.O_BUSY, 1'b0);
      chk("rst_done", bus.O_DONE, 1'b0);
      chk("rst_strobes", {bus.O_GPU_READ, bus.O_GPU_WRITE}, 2'b00);
      chk("rst_addr", bus.O_GPU_ADDR, 0);
      chk("rst_data", bus.O_GPU_DATA, 0);
      chk("rst_pix", bus.O_PIX_CNT, 0);

      // FILL 3x2 at (2,1)
      issue(1'b0, 2, 1, 3, 2, 16'hF800);
      wait_done("fill3x2");
      check_cmd("fill3x2", 1'b0, 1'b1);
      if (wa_q.size() == 6) chk("fill3x2_addr3", wa_q[3], 1282);
      else chk("fill3x2_count", wa_q.size(), 6);

      // INVERT single pixel, SRAM returns 00FF
      ovr_en  = 1'b1;
      ovr_val = 16'h00FF;
      issue(1'b1, 100, 0, 1, 1, 16'h1234);
      wait_done("inv1");
      check_cmd("inv1", 1'b1, 1'b1);
      if (wd_q.size() == 1) chk("inv1_data", wd_q[0], 16'hFF00);
      else chk("inv1_count", wd_q.size(), 1);
      ovr_en = 1'b0;

      // FILL 4x1 with a 5-cycle video pulse after the 2nd write
      issue(1'b0, 0, 0, 4, 1, 16'h07E0);
      n = 0;
      while (wa_q.size() < 2 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      vid_force = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      vid_force = 1'b0;
      wait_done("vid");
      check_cmd("vid", 1'b0, 1'b0);
      if (wa_q.size() == 4) begin
         chk("vid_resume_addr", wa_q[2], 2);
         chk("vid_gap", wc_q[2] > wc_q[1] + 5, 1);
      end else chk("vid_count", wa_q.size(), 4);

      // Clipping at bottom-right corner
      issue(1'b0, 638, 479, 5, 1, 16'h001F);
      wait_done("clip");
      check_cmd("clip", 1'b0, 1'b1);
      if (wa_q.size() == 2) chk("clip_addr0", wa_q[0], 307198);
      else chk("clip_count", wa_q.size(), 2);

      // Empty commands
      issue(1'b0, 640, 5, 4, 4, 16'hAAAA);
      wait_done("empty_x");
      check_cmd("empty_x", 1'b0, 1'b1);
      issue(1'b1, 5, 5, 4, 0, 16'hAAAA);
      wait_done("empty_h");
      check_cmd("empty_h", 1'b1, 1'b1);

      // Reset after the 3rd write of a W=10 FILL
      issue(1'b0, 10, 10, 10, 1, 16'h5555);
      n = 0;
      while (wa_q.size() < 3 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_strobes", {bus.O_GPU_READ, bus.O_GPU_WRITE}, 2'b00);
      chk("mid_rst_busy", bus.O_BUSY, 1'b0);
      chk("mid_rst_pix", bus.O_PIX_CNT, 0);
      chk("mid_rst_ready", bus.O_CMD_READY, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mid_rst_nwr", wa_q.size(), 3);
      issue(1'b0, 20, 20, 2, 2, 16'h0F0F);
      wait_done("post_rst");
      check_cmd("post_rst", 1'b0, 1'b1);

      // Randomized commands with random video activity
      vid_rand = 1'b1;
      for (int k = 0; k < 16; k++) begin
         m = 1'($urandom);
         x = ($urandom_range(0, 1) == 1) ? $urandom_range(600, 660) : $urandom_range(0, 639);
         y = ($urandom_range(0, 1) == 1) ? $urandom_range(470, 490) : $urandom_range(0, 479);
         w = $urandom_range(0, 24);
         h = $urandom_range(0, 6);
         issue(m, x, y, w, h, 16'($urandom));
         wait_done($sformatf("rnd%0d", k));
         check_cmd($sformatf("rnd%0d", k), m, 1'b0);
      end
      vid_rand = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
